id_regfile: RTL

- Decode-stage integer register file; receiving end of the writeback-to-decode interface (WB_ID_regwrite / WB_ID_rd / WB_ID_res).
- Commits writeback results and supplies rs1/rs2 operands, with same-cycle write-through bypass.
- Exposes a 4-phase req/ack debug access port, usable only while the core is halted by debug.

---
 rtl/id_regfile_if.sv | 34 +++
 rtl/id_regfile.sv | 130 +++++++++++++
 2 files changed

// File: rtl/id_regfile_if.sv
// Writeback-to-decode, operand read and debug access bundle
// for the decode-stage register file.
interface id_regfile_if #(
    parameter int XLEN = 32
);
    logic            debug;
    logic            WB_ID_regwrite;
    logic [4:0]      WB_ID_rd;
    logic [XLEN-1:0] WB_ID_res;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            dbg_req;
    logic            dbg_we;
    logic [4:0]      dbg_addr;
    logic [XLEN-1:0] dbg_wdata;
    logic [XLEN-1:0] dbg_rdata;
    logic            dbg_ack;

    modport master (
        output debug, WB_ID_regwrite, WB_ID_rd, WB_ID_res,
        output rs1_addr, rs2_addr,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  rs1_data, rs2_data, dbg_rdata, dbg_ack
    );

    modport slave (
        input  debug, WB_ID_regwrite, WB_ID_rd, WB_ID_res,
        input  rs1_addr, rs2_addr,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output rs1_data, rs2_data, dbg_rdata, dbg_ack
    );
endinterface

// File: rtl/id_regfile.sv
// Decode-stage integer register file with writeback bypass
// and a 4-phase debug access port (active only while halted).
module id_regfile #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] SP_RESET = '0
) (
    input logic        clk,
    input logic        Rst,
    id_regfile_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [XLEN-1:0] r_regs [32];
    logic            r_we;
    logic [4:0]      r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_rdata;
    logic            r_ack;

    logic            w_latch;
    logic            w_done;
    logic            w_release;
    logic            w_pipe_we;
    logic            w_dbg_we;
    logic [XLEN-1:0] w_dbg_rd;

    // Pipeline commits are suppressed while halted; debug writes
    // only happen in ACCESS with debug still high, so they never collide.
    assign w_pipe_we = bus.WB_ID_regwrite && (bus.WB_ID_rd != 5'd0)
                       && !bus.debug;
    assign w_dbg_we  = w_done && r_we && (r_addr != 5'd0);
    assign w_dbg_rd  = (r_addr == 5'd0) ? '0 : r_regs[r_addr];

    // Debug FSM next-state and per-edge strobes.
    always_comb begin
        w_next    = r_state;
        w_latch   = 1'b0;
        w_done    = 1'b0;
        w_release = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.debug && bus.dbg_req) begin
                    w_latch = 1'b1;
                    w_next  = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (bus.debug) begin
                    w_done = 1'b1;
                    w_next = S_DONE;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_DONE: begin
                if (!bus.dbg_req) begin
                    w_release = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Debug FSM state, request latch, ack and read-result registers.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                r_we    <= bus.dbg_we;
                r_addr  <= bus.dbg_addr;
                r_wdata <= bus.dbg_wdata;
            end
            if (w_done) begin
                r_ack   <= 1'b1;
                r_rdata <= r_we ? r_wdata : w_dbg_rd;
            end else if (w_release) begin
                r_ack <= 1'b0;
            end
        end
    end

    // Register storage; x0 is never written so it stays zero.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
            r_regs[2] <= SP_RESET;
        end else if (w_pipe_we) begin
            r_regs[bus.WB_ID_rd] <= bus.WB_ID_res;
        end else if (w_dbg_we) begin
            r_regs[r_addr] <= r_wdata;
        end
    end

    // Operand reads with same-cycle writeback bypass.
    always_comb begin
        bus.rs1_data = r_regs[bus.rs1_addr];
        bus.rs2_data = r_regs[bus.rs2_addr];
        if (w_pipe_we && bus.WB_ID_rd == bus.rs1_addr) begin
            bus.rs1_data = bus.WB_ID_res;
        end
        if (w_pipe_we && bus.WB_ID_rd == bus.rs2_addr) begin
            bus.rs2_data = bus.WB_ID_res;
        end
        if (bus.rs1_addr == 5'd0) begin
            bus.rs1_data = '0;
        end
        if (bus.rs2_addr == 5'd0) begin
            bus.rs2_data = '0;
        end
    end

    assign bus.dbg_rdata = r_rdata;
    assign bus.dbg_ack   = r_ack;
endmodule
